// File: rtl/q15_mac_accum_if.sv
// Valid/ready beat stream into the Q1.15 accumulator and its result channel.
// The master drives the product stream and consumes results; the slave is the accumulator.
interface q15_mac_accum_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] in_prod;
    logic              in_last;
    logic              out_vld;
    logic              out_rdy;
    logic [DATA_W-1:0] out_res;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;

    modport master (
        output in_vld, in_prod, in_last, out_rdy,
        input  in_rdy, out_vld, out_res, out_cnt, out_ovf
    );

    modport slave (
        input  in_vld, in_prod, in_last, out_rdy,
        output in_rdy, out_vld, out_res, out_cnt, out_ovf
    );
endinterface

// File: rtl/q15_mac_accum.sv
// Packet accumulator for signed Q1.15 products: guarded saturating sum per packet,
// emitted as one saturated Q1.15 result with term count and overflow flag.
module q15_mac_accum #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    q15_mac_accum_if.slave       bus
);
    typedef enum logic [0:0] {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]  RES_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  RES_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {overflow, clamped sum}; overflow when both operands share a sign the sum lacks.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        logic             v;
        s = a + b;
        v = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        if (v) begin
            s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            s = s;
        end
        return {v, s};
    endfunction

    // Returns {overflow, Q1.15 value} after clamping the guarded sum to the output range.
    function automatic logic [DATA_W:0] narrow(input logic [ACC_W-1:0] a);
        if ($signed(a) > $signed(RES_MAX)) begin
            return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end else if ($signed(a) < $signed(RES_MIN)) begin
            return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, a[DATA_W-1:0]};
        end
    endfunction

    state_t             r_state;
    logic               r_in_rdy;
    logic               r_out_vld;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [DATA_W-1:0]  r_out_res;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_out_ovf;

    state_t             w_state_nxt;
    logic               w_in_rdy_nxt;
    logic               w_out_vld_nxt;
    logic               w_accept;
    logic               w_release;
    logic               w_finish;
    logic [ACC_W-1:0]   w_sext;
    logic [ACC_W:0]     w_add;
    logic [DATA_W:0]    w_narrow;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Acceptance is gated by the registered ready, so nothing is taken during or just after reset.
    assign w_accept  = bus.in_vld & r_in_rdy;
    assign w_release = r_out_vld & bus.out_rdy;
    assign w_finish  = w_accept & bus.in_last;
    assign w_sext    = {{(ACC_W-DATA_W){bus.in_prod[DATA_W-1]}}, bus.in_prod};
    assign w_add     = sat_add(r_acc, w_sext);
    assign w_narrow  = narrow(w_add[ACC_W-1:0]);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + CNT_ONE);

    // Next-state logic; clr overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC:  w_state_nxt = w_finish  ? ST_HOLD : ST_ACC;
                ST_HOLD: w_state_nxt = w_release ? ST_ACC  : ST_HOLD;
                default: w_state_nxt = ST_ACC;
            endcase
        end
    end

    // Handshake outputs follow the state being entered so they can be registered.
    always_comb begin
        w_in_rdy_nxt  = 1'b0;
        w_out_vld_nxt = 1'b0;
        case (w_state_nxt)
            ST_ACC:  w_in_rdy_nxt  = 1'b1;
            ST_HOLD: w_out_vld_nxt = 1'b1;
            default: w_in_rdy_nxt  = 1'b0;
        endcase
    end

    // State and handshake registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_ACC;
            r_in_rdy  <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_in_rdy  <= w_in_rdy_nxt;
            r_out_vld <= w_out_vld_nxt;
        end
    end

    // Running packet sum, term count and sticky overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_ovf <= 1'b0;
        end else if (i_clr || w_release) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_add[ACC_W-1:0];
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_add[ACC_W];
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
            r_ovf <= r_ovf;
        end
    end

    // Result registers capture only on the final beat and otherwise keep their last values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_res <= {DATA_W{1'b0}};
            r_out_cnt <= {CNT_W{1'b0}};
            r_out_ovf <= 1'b0;
        end else if (!i_clr && w_finish) begin
            r_out_res <= w_narrow[DATA_W-1:0];
            r_out_cnt <= w_cnt_inc;
            r_out_ovf <= r_ovf | w_add[ACC_W] | w_narrow[DATA_W];
        end else begin
            r_out_res <= r_out_res;
            r_out_cnt <= r_out_cnt;
            r_out_ovf <= r_out_ovf;
        end
    end

    assign bus.in_rdy  = r_in_rdy;
    assign bus.out_vld = r_out_vld;
    assign bus.out_res = r_out_res;
    assign bus.out_cnt = r_out_cnt;
    assign bus.out_ovf = r_out_ovf;
endmodule

// File: tb/tb_q15_mac_accum.sv
// Directed-vector bench for q15_mac_accum: each task drives one scenario and checks
// hand-computed results inline.
module tb_q15_mac_accum;
    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   errors;

    q15_mac_accum_if #(.DATA_W(16), .CNT_W(8)) bus ();

    q15_mac_accum #(.DATA_W(16), .ACC_W(24), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic beat(input logic [15:0] p, input logic l);
        bus.in_vld  = 1'b1;
        bus.in_prod = p;
        bus.in_last = l;
        @(posedge clk); #1;
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic take_result();
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0;
        bus.in_vld = 1'b0; bus.in_prod = 16'h0000; bus.in_last = 1'b0; bus.out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b expected 0", bus.in_rdy); end
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", bus.out_vld); end
        checks++; if ({bus.out_res, bus.out_cnt, bus.out_ovf} !== 25'h0) begin errors++; $display("FAIL reset_outputs: got %h/%h/%b expected 0/0/0", bus.out_res, bus.out_cnt, bus.out_ovf); end
        rst_n = 1'b1;
        #2;
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_before_edge: got %b expected 0", bus.in_rdy); end
        @(posedge clk); #1;
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_after_edge: got %b expected 1", bus.in_rdy); end
        // Asynchronous reset while a result is held, between clock edges.
        beat(16'h1234, 1'b1);
        checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL async_pre_vld: got %b expected 1", bus.out_vld); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b0) begin errors++; $display("FAIL async_handshake: got vld=%b rdy=%b expected 0/0", bus.out_vld, bus.in_rdy); end
        checks++; if (bus.out_res !== 16'h0000 || bus.out_cnt !== 8'd0) begin errors++; $display("FAIL async_outputs: got res=%h cnt=%0d expected 0/0", bus.out_res, bus.out_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        beat(16'h4000, 1'b0);
        beat(16'h2000, 1'b0);
        beat(16'hF000, 1'b1);
        checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b expected 1", bus.out_vld); end
        checks++; if (bus.out_res !== 16'h5000) begin errors++; $display("FAIL basic_res: got %h expected 5000", bus.out_res); end
        checks++; if (bus.out_cnt !== 8'd3) begin errors++; $display("FAIL basic_cnt: got %0d expected 3", bus.out_cnt); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", bus.out_ovf); end
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL basic_hold_rdy: got %b expected 0", bus.in_rdy); end
        take_result();
        checks++; if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin errors++; $display("FAIL basic_release: got vld=%b rdy=%b expected 0/1", bus.out_vld, bus.in_rdy); end
    endtask

    task automatic test_saturation();
        beat(16'h7FFF, 1'b0);
        beat(16'h7FFF, 1'b1);
        checks++; if (bus.out_res !== 16'h7FFF || bus.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_pos: got res=%h ovf=%b expected 7fff/1", bus.out_res, bus.out_ovf); end
        take_result();
        beat(16'h8000, 1'b0);
        beat(16'h8000, 1'b1);
        checks++; if (bus.out_res !== 16'h8000 || bus.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_neg: got res=%h ovf=%b expected 8000/1", bus.out_res, bus.out_ovf); end
        checks++; if (bus.out_cnt !== 8'd2) begin errors++; $display("FAIL sat_neg_cnt: got %0d expected 2", bus.out_cnt); end
        take_result();
    endtask

    task automatic test_backpressure();
        beat(16'h0300, 1'b0);
        beat(16'h0200, 1'b1);
        bus.in_vld = 1'b1; bus.in_prod = 16'h7000; bus.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_vld !== 1'b1 || bus.in_rdy !== 1'b0) begin errors++; $display("FAIL bp_handshake[%0d]: got vld=%b rdy=%b expected 1/0", i, bus.out_vld, bus.in_rdy); end
            checks++; if (bus.out_res !== 16'h0500 || bus.out_cnt !== 8'd2) begin errors++; $display("FAIL bp_stable[%0d]: got res=%h cnt=%0d expected 0500/2", i, bus.out_res, bus.out_cnt); end
        end
        bus.in_vld = 1'b0; bus.in_last = 1'b0;
        take_result();
        beat(16'h0100, 1'b1);
        checks++; if (bus.out_res !== 16'h0100 || bus.out_cnt !== 8'd1) begin errors++; $display("FAIL bp_next: got res=%h cnt=%0d expected 0100/1", bus.out_res, bus.out_cnt); end
        take_result();
    endtask

    task automatic test_single_beat();
        beat(16'h1234, 1'b1);
        checks++; if (bus.out_vld !== 1'b1 || bus.out_res !== 16'h1234) begin errors++; $display("FAIL single_res: got vld=%b res=%h expected 1/1234", bus.out_vld, bus.out_res); end
        checks++; if (bus.out_cnt !== 8'd1 || bus.out_ovf !== 1'b0) begin errors++; $display("FAIL single_cnt_ovf: got cnt=%0d ovf=%b expected 1/0", bus.out_cnt, bus.out_ovf); end
        take_result();
    endtask

    task automatic test_clr();
        beat(16'h1000, 1'b0);
        beat(16'h1000, 1'b0);
        // The beat presented alongside clr must be dropped.
        clr = 1'b1;
        beat(16'h4000, 1'b0);
        clr = 1'b0;
        beat(16'h0800, 1'b1);
        checks++; if (bus.out_res !== 16'h0800 || bus.out_cnt !== 8'd1) begin errors++; $display("FAIL clr_mid_packet: got res=%h cnt=%0d expected 0800/1", bus.out_res, bus.out_cnt); end
        take_result();
        beat(16'h0111, 1'b1);
        checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL clr_hold_pre: got %b expected 1", bus.out_vld); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++; if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin errors++; $display("FAIL clr_hold_drop: got vld=%b rdy=%b expected 0/1", bus.out_vld, bus.in_rdy); end
        checks++; if (bus.out_res !== 16'h0111) begin errors++; $display("FAIL clr_hold_keep: got %h expected 0111", bus.out_res); end
        beat(16'h0222, 1'b1);
        checks++; if (bus.out_res !== 16'h0222 || bus.out_cnt !== 8'd1) begin errors++; $display("FAIL clr_after_hold: got res=%h cnt=%0d expected 0222/1", bus.out_res, bus.out_cnt); end
        take_result();
    endtask

    task automatic test_cnt_saturation();
        for (int i = 0; i < 299; i++) begin
            beat(16'h0001, 1'b0);
        end
        beat(16'hFED5, 1'b1);
        checks++; if (bus.out_cnt !== 8'd255) begin errors++; $display("FAIL cnt_sat: got %0d expected 255", bus.out_cnt); end
        checks++; if (bus.out_res !== 16'h0000 || bus.out_ovf !== 1'b0) begin errors++; $display("FAIL cnt_sat_res: got res=%h ovf=%b expected 0000/0", bus.out_res, bus.out_ovf); end
        take_result();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_single_beat();
        test_clr();
        test_cnt_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
